serial_bus_arbiter: RTL and testbench

Parametrised shared-bus transmitter for the multi-node FPGA bus. N_NODES requesters each present a destination address, a 2-bit mode and a DATA_W payload. A round-robin arbiter grants one node at a time, and the granted request is serialised MSB-first onto the single-bit bus_out. Each frame carries a CRC-4 that the block generates in hardware, so per-node CRC inputs are no longer used.

---
 rtl/sbus_pkg.sv | 22 ++
 rtl/crc4_serial.sv | 27 ++
 rtl/serial_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_serial_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbus_pkg.sv
// Shared types and constants for the serial bus arbiter and its CRC engine.
package sbus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_SEND  = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // CRC-4, x^4 + x + 1, seeded with zero
  localparam logic [3:0] CRC_POLY  = 4'b0011;
  localparam logic [3:0] CRC_INIT  = 4'b0000;
  localparam logic       START_BIT = 1'b1;

  // start + src + dst + mode + data + crc
  function automatic int unsigned frame_len(input int unsigned addr_w,
                                            input int unsigned data_w);
    return 7 + 2 * addr_w + data_w;
  endfunction

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 accumulator, one input bit per enabled cycle, MSB-first message order.
module crc4_serial
  import sbus_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);

  logic fb;

  assign fb = din ^ crc[3];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= {crc[2:0], 1'b0} ^ (fb ? CRC_POLY : 4'b0000);
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter that grants one node at a time and serialises its request
// MSB-first onto bus_out with a hardware-generated CRC-4 trailer.
module serial_bus_arbiter
  import sbus_pkg::*;
#(
  parameter int unsigned N_NODES = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned IFG     = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_NODES-1:0]        req_valid,
  output logic [N_NODES-1:0]        req_ready,
  input  logic [N_NODES*ADDR_W-1:0] req_dst,
  input  logic [N_NODES*2-1:0]      req_mode,
  input  logic [N_NODES*DATA_W-1:0] req_data,
  output logic                      bus_out,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         done_src
);

  localparam int unsigned FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int unsigned PAY_W     = FRAME_LEN - 5;
  localparam int unsigned PAD_W     = PAY_W - 3;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);
  localparam int unsigned GAP_W     = 4;
  localparam int unsigned NODE_W    = $clog2(N_NODES);

  state_e              state;
  logic [ADDR_W-1:0]   rr_ptr;
  logic [ADDR_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]   src_q;
  logic [PAY_W-1:0]    shreg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [GAP_W-1:0]    gap_cnt;
  logic [3:0]          crc;

  logic                any_valid_c;
  logic                found_c;
  logic [NODE_W-1:0]   idx_c;
  logic [ADDR_W-1:0]   win_c;
  logic [ADDR_W-1:0]   sel_dst_c;
  logic [1:0]          sel_mode_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic                crc_clear_c;
  logic                crc_en_c;

  assign any_valid_c = |req_valid;

  // First requester at or above rr_ptr, wrapping modulo N_NODES
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    win_c   = rr_ptr;
    for (int unsigned k = 0; k < N_NODES; k++) begin
      idx_c = NODE_W'((32'(rr_ptr) + k) % N_NODES);
      if (!found_c && req_valid[idx_c]) begin
        found_c = 1'b1;
        win_c   = ADDR_W'(idx_c);
      end
    end
  end

  // Field mux for the node currently being granted
  always_comb begin
    sel_dst_c  = '0;
    sel_mode_c = '0;
    sel_data_c = '0;
    for (int unsigned n = 0; n < N_NODES; n++) begin
      if (grant_idx == ADDR_W'(n)) begin
        sel_dst_c  = req_dst[n*ADDR_W +: ADDR_W];
        sel_mode_c = req_mode[n*2 +: 2];
        sel_data_c = req_data[n*DATA_W +: DATA_W];
      end
    end
  end

  // CRC sees each payload bit on the same edge that places it on the bus
  assign crc_clear_c = (state == S_GRANT);
  assign crc_en_c    = (state == S_SEND) && (bit_cnt < CNT_W'(PAY_W));

  crc4_serial u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (crc_clear_c),
    .en      (crc_en_c),
    .din     (shreg[PAY_W-1]),
    .crc     (crc)
  );

  // bit_cnt is the index of the frame bit currently driven on bus_out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      src_q     <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      req_ready <= '0;
      bus_out   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_src  <= '0;
    end else begin
      req_ready <= '0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          bus_out <= 1'b0;
          busy    <= any_valid_c;
          if (any_valid_c) begin
            state     <= S_GRANT;
            grant_idx <= win_c;
            req_ready <= N_NODES'(1) << win_c;
          end
        end

        S_GRANT: begin
          src_q   <= grant_idx;
          shreg   <= {grant_idx, sel_dst_c, sel_mode_c, sel_data_c};
          bus_out <= START_BIT;
          bit_cnt <= '0;
          rr_ptr  <= (grant_idx == ADDR_W'(N_NODES - 1)) ? '0 : grant_idx + ADDR_W'(1);
          state   <= S_SEND;
        end

        S_SEND: begin
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
            bus_out <= 1'b0;
            gap_cnt <= '0;
            if (IFG == 0) begin
              state <= S_IDLE;
              busy  <= any_valid_c;
            end else begin
              state <= S_GAP;
            end
          end else if (bit_cnt == CNT_W'(PAY_W)) begin
            // Payload exhausted: emit crc MSB, park the rest in the shifter
            bus_out <= crc[3];
            shreg   <= {crc[2:0], {PAD_W{1'b0}}};
          end else begin
            bus_out <= shreg[PAY_W-1];
            shreg   <= shreg << 1;
          end
          if (bit_cnt == CNT_W'(FRAME_LEN - 2)) begin
            done     <= 1'b1;
            done_src <= src_q;
          end
        end

        S_GAP: begin
          bus_out <= 1'b0;
          gap_cnt <= gap_cnt + GAP_W'(1);
          if (gap_cnt == GAP_W'(IFG - 1)) begin
            state <= S_IDLE;
            // Stay busy across the turnaround when another request is already waiting
            busy  <= any_valid_c;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter: directed frames checked bit-exactly at each done pulse.
module tb_serial_bus_arbiter;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 64;
  localparam int FL = 79;

  typedef struct {
    logic [3:0]    src;
    logic [FL-1:0] bits;
  } exp_t;

  logic              clock;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_dst;
  logic [N*2-1:0]    req_mode;
  logic [N*DW-1:0]   req_data;
  logic              bus_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     done_src;

  logic [N-1:0]      sp_valid [2];
  logic [N-1:0]      sp_ready [2];
  logic              sp_bus   [2];
  logic              sp_busy  [2];
  logic              sp_done  [2];
  logic [AW-1:0]     sp_src   [2];

  exp_t              sb[$];
  int                n_checks;
  int                n_fails;
  int                cyc;

  logic [FL-1:0]     cap;
  logic              grant_prev;
  int                start_cyc;

  serial_bus_arbiter #(.N_NODES(N), .ADDR_W(AW), .DATA_W(DW), .IFG(2)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_mode(req_mode), .req_data(req_data),
    .bus_out(bus_out), .busy(busy), .done(done), .done_src(done_src)
  );

  serial_bus_arbiter #(.N_NODES(N), .ADDR_W(AW), .DATA_W(DW), .IFG(0)) dut_ifg0 (
    .clock(clock), .reset_n(reset_n), .req_valid(sp_valid[0]), .req_ready(sp_ready[0]),
    .req_dst(req_dst), .req_mode(req_mode), .req_data(req_data),
    .bus_out(sp_bus[0]), .busy(sp_busy[0]), .done(sp_done[0]), .done_src(sp_src[0])
  );

  serial_bus_arbiter #(.N_NODES(N), .ADDR_W(AW), .DATA_W(DW), .IFG(3)) dut_ifg3 (
    .clock(clock), .reset_n(reset_n), .req_valid(sp_valid[1]), .req_ready(sp_ready[1]),
    .req_dst(req_dst), .req_mode(req_mode), .req_data(req_data),
    .bus_out(sp_bus[1]), .busy(sp_busy[1]), .done(sp_done[1]), .done_src(sp_src[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: start, src, dst, mode, data, then serial x^4+x+1 CRC over src..data
  function automatic logic [FL-1:0] frame_model(input logic [3:0] src, input logic [3:0] dst,
                                                input logic [1:0] mode, input logic [63:0] data);
    logic [73:0] pay;
    logic [3:0]  c;
    logic        fb;
    pay = {src, dst, mode, data};
    c   = 4'h0;
    for (int i = 73; i >= 0; i--) begin
      fb = pay[i] ^ c[3];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return {1'b1, pay, c};
  endfunction

  task automatic set_node(input int i, input logic [3:0] dst, input logic [1:0] mode,
                          input logic [63:0] data);
    req_dst[i*AW +: AW]  = dst;
    req_mode[i*2 +: 2]   = mode;
    req_data[i*DW +: DW] = data;
  endtask

  task automatic push_model(input int src, input logic [3:0] dst, input logic [1:0] mode,
                            input logic [63:0] data);
    exp_t e;
    e.src  = 4'(src);
    e.bits = frame_model(4'(src), dst, mode, data);
    sb.push_back(e);
  endtask

  task automatic send_one(input int i);
    logic got;
    got = 1'b0;
    @(posedge clock); #1;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (req_ready[i]) got = 1'b1;
    end
    check("grant_seen", 128'(got), 1);
    @(posedge clock); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clock);
      c++;
    end
    check("scoreboard_drained", 128'(sb.size()), 0);
    repeat (4) @(posedge clock);
    #1;
  endtask

  // Two queued nodes on an IFG-variant instance: start spacing and a single busy fall
  task automatic spacing_test(input int k, input int exp_gap);
    int          starts[$];
    int          falls;
    logic        prev_busy;
    logic        prev_rdy;
    logic [N-1:0] rdy;
    falls     = 0;
    prev_busy = 1'b0;
    prev_rdy  = 1'b0;
    @(posedge clock); #1;
    sp_valid[k] = 16'h0204;
    for (int c = 0; c < 2 * (FL + 20) + 40; c++) begin
      @(negedge clock);
      if (prev_rdy) begin
        check("spacing_start_bit", 128'(sp_bus[k]), 1);
        starts.push_back(c);
      end
      if (prev_busy && !sp_busy[k]) falls++;
      prev_busy = sp_busy[k];
      rdy       = sp_ready[k];
      prev_rdy  = |rdy;
      if (|rdy) begin
        @(posedge clock); #1;
        sp_valid[k] = sp_valid[k] & ~rdy;
      end
    end
    check("spacing_start_count", 128'(starts.size()), 2);
    if (starts.size() == 2) check("start_spacing", 128'(starts[1] - starts[0]), 128'(exp_gap));
    check("busy_falls", 128'(falls), 1);
    check("busy_final", 128'(sp_busy[k]), 0);
  endtask

  // Monitor: collect bus_out every cycle, compare a whole frame against the scoreboard at done
  initial begin
    exp_t e;
    cap        = '0;
    grant_prev = 1'b0;
    start_cyc  = 0;
    forever begin
      @(negedge clock);
      cap = {cap[FL-2:0], bus_out};
      if (grant_prev) begin
        check("start_bit", 128'(bus_out), 1);
        start_cyc = cyc;
      end
      grant_prev = |req_ready;
      if (|req_ready) check("ready_onehot", 128'($countones(req_ready)), 1);
      if (done) begin
        check("frame_pending", 128'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("frame_bits", 128'(cap), 128'(e.bits));
          check("done_src", 128'(done_src), 128'(e.src));
          check("done_bit_index", 128'(cyc - start_cyc + 1), 128'(FL));
        end
      end
    end
  end

  initial begin
    exp_t         e;
    int           grants;
    logic [FL-1:0] bits;

    n_checks    = 0;
    n_fails     = 0;
    cyc         = 0;
    reset_n     = 1'b0;
    req_valid   = '0;
    req_dst     = '0;
    req_mode    = '0;
    req_data    = '0;
    sp_valid[0] = '0;
    sp_valid[1] = '0;
    #1;
    check("rst_bus_out", 128'(bus_out), 0);
    check("rst_busy", 128'(busy), 0);
    check("rst_done", 128'(done), 0);
    check("rst_done_src", 128'(done_src), 0);
    check("rst_req_ready", 128'(req_ready), 0);
    for (int k = 0; k < 2; k++) begin
      check("rst_sp_outputs", 128'({sp_ready[k], sp_bus[k], sp_busy[k], sp_done[k], sp_src[k]}), 0);
    end
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // All-zero frame: single start bit followed by 78 zeros
    set_node(0, 4'h0, 2'd0, 64'h0);
    bits     = '0;
    bits[78] = 1'b1;
    e.src    = 4'h0;
    e.bits   = bits;
    sb.push_back(e);
    send_one(0);
    wait_drain(200);

    // dst=1, mode=1, data=1: message is x^66+x^64+1, so crc = (x^70+x^68+x^4) mod g = 0001
    set_node(0, 4'h1, 2'd1, 64'h1);
    e.src  = 4'h0;
    e.bits = {1'b1, 4'h0, 4'h1, 2'b01, 64'h1, 4'b0001};
    sb.push_back(e);
    send_one(0);
    wait_drain(200);

    // Fields changed mid-frame must not leak into the frame in flight
    set_node(5, 4'h7, 2'd2, 64'hA5A5_5A5A_F0F0_0F0F);
    push_model(5, 4'h7, 2'd2, 64'hA5A5_5A5A_F0F0_0F0F);
    send_one(5);
    repeat (10) @(posedge clock);
    #1;
    set_node(5, 4'h2, 2'd0, 64'h5A5A_A5A5_0F0F_F0F0);
    wait_drain(200);

    // Reset at bit 30: outputs clear at once and no done follows
    set_node(0, 4'h3, 2'd1, 64'hFFFF_0000_FFFF_0000);
    send_one(0);
    repeat (29) @(posedge clock);
    #2;
    check("busy_before_reset", 128'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_bus_out", 128'(bus_out), 0);
    check("midrst_busy", 128'(busy), 0);
    check("midrst_done", 128'(done), 0);
    check("midrst_done_src", 128'(done_src), 0);
    check("midrst_req_ready", 128'(req_ready), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(posedge clock);
    #1;

    // Round robin from a fresh pointer: 0, 3, 15 repeating
    set_node(0, 4'hA, 2'd2, 64'h0123_4567_89AB_CDEF);
    set_node(3, 4'h5, 2'd3, 64'hDEAD_BEEF_0000_FFFF);
    set_node(15, 4'hF, 2'd1, 64'h8000_0000_0000_0001);
    for (int r = 0; r < 2; r++) begin
      push_model(0, 4'hA, 2'd2, 64'h0123_4567_89AB_CDEF);
      push_model(3, 4'h5, 2'd3, 64'hDEAD_BEEF_0000_FFFF);
      push_model(15, 4'hF, 2'd1, 64'h8000_0000_0000_0001);
    end
    @(posedge clock); #1;
    req_valid = 16'h8009;
    grants    = 0;
    for (int c = 0; c < 1000 && grants < 6; c++) begin
      @(negedge clock);
      if (|req_ready) grants++;
    end
    check("fair_grants", 128'(grants), 6);
    @(posedge clock); #1;
    req_valid = '0;
    wait_drain(300);

    spacing_test(0, FL + 2);
    spacing_test(1, FL + 3 + 2);

    check("scoreboard_empty_at_end", 128'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
